// File: rtl/alut_pkg25.sv
// Shared ALUT definitions: table geometry, entry field layout and the aging FSM states.
// Used by the aging scheduler and kept in step with the dual-port table memory.
package alut_pkg25;

    localparam int ALUT_DW           = 83;
    localparam int ALUT_DD           = 256;
    localparam int ALUT_AW           = 8;
    localparam int ALUT_TW           = 32;
    localparam int ALUT_VB           = 82;
    localparam int ALUT_TS_LSB       = 0;
    localparam int ALUT_TS_MSB       = ALUT_TW - 1;
    localparam int ALUT_AGE_INTERVAL = 1024;

    typedef enum logic [2:0] {
        AGE_IDLE = 3'd0,
        AGE_RD   = 3'd1,
        AGE_CHK  = 3'd2,
        AGE_WR   = 3'd3,
        AGE_DONE = 3'd4
    } age_state_e;

endpackage

// File: rtl/alut_age_timer25.sv
// Free-running entry timestamp plus, when ALUT_AGE_AUTO_EN is defined, an interval
// counter that requests a sweep every AGE_INTERVAL ticks (held pending while busy).
module alut_age_timer25 #(
    parameter int TW           = 32,
    parameter int AGE_INTERVAL = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          accept_i,
    output logic [TW-1:0] cur_time_o,
    output logic          auto_start_o
);

    logic [TW-1:0] time_q;

    // Timestamp advances once per tick and wraps modulo 2^TW.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            time_q <= '0;
        end else if (tick_i) begin
            time_q <= time_q + TW'(1);
        end else begin
            time_q <= time_q;
        end
    end

    assign cur_time_o = time_q;

`ifdef ALUT_AGE_AUTO_EN
    logic [31:0] ivl_q;
    logic        pend_q;
    logic        expire_s;

    assign expire_s = tick_i && (ivl_q == 32'(AGE_INTERVAL - 1));

    // An expiry that cannot launch immediately stays pending until the FSM accepts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ivl_q  <= 32'd0;
            pend_q <= 1'b0;
        end else begin
            if (expire_s) begin
                ivl_q <= 32'd0;
            end else if (tick_i) begin
                ivl_q <= ivl_q + 32'd1;
            end else begin
                ivl_q <= ivl_q;
            end
            if (accept_i) begin
                pend_q <= 1'b0;
            end else if (expire_s) begin
                pend_q <= 1'b1;
            end else begin
                pend_q <= pend_q;
            end
        end
    end

    assign auto_start_o = expire_s || pend_q;
`else
    logic unused_auto_s;
    assign unused_auto_s = accept_i ^ (AGE_INTERVAL == 0);
    assign auto_start_o  = 1'b0;
`endif

endmodule

// File: rtl/alut_age_sched25.sv
// ALUT aging scheduler: sweeps the table through the age port (read, check, write-back)
// and invalidates stale entries. ALUT_AGE_AUTO_EN adds periodic automatic sweeps.
module alut_age_sched25
    import alut_pkg25::*;
#(
    parameter int DW           = ALUT_DW,
    parameter int DD           = ALUT_DD,
    parameter int TW           = ALUT_TW,
    parameter int VB           = ALUT_VB,
    parameter int AGE_INTERVAL = ALUT_AGE_INTERVAL
) (
    input  logic          pclk25,
    input  logic          prst25,
    input  logic          age_en25,
    input  logic          age_start25,
    input  logic [TW-1:0] age_thresh25,
    input  logic          tick25,
    input  logic [7:0]    mem_addr_add25,
    input  logic          mem_write_add25,
    input  logic [DW-1:0] mem_read_data_age25,
    output logic [7:0]    mem_addr_age25,
    output logic          mem_write_age25,
    output logic [DW-1:0] mem_write_data_age25,
    output logic [TW-1:0] cur_time25,
    output logic          sweep_busy25,
    output logic          sweep_done25,
    output logic [8:0]    aged_cnt25
);

    localparam logic [7:0] LAST_ADDR = 8'(DD - 1);

    age_state_e    state_q, state_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    cnt_q, cnt_d;
    logic          hazard_q, hazard_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          auto_start_s;
    logic          start_s;
    logic          add_hit_s;
    logic          advance_s;
    logic [TW-1:0] age_s;
    logic          expired_s;

    alut_age_timer25 #(
        .TW           (TW),
        .AGE_INTERVAL (AGE_INTERVAL)
    ) u_timer (
        .clk_i        (pclk25),
        .rst_i        (prst25),
        .tick_i       (tick25),
        .accept_i     ((state_q == AGE_IDLE) && age_en25),
        .cur_time_o   (cur_time25),
        .auto_start_o (auto_start_s)
    );

    assign start_s   = (age_start25 || auto_start_s) && age_en25;
    assign add_hit_s = mem_write_add25 && (mem_addr_add25 == addr_q);
    // Modulo subtraction keeps the age correct across timestamp wrap.
    assign age_s     = cur_time25 - mem_read_data_age25[TW-1:0];
    assign expired_s = mem_read_data_age25[VB] && (age_s > age_thresh25);

    // Sweep sequencing: next state, address, hazard latch, write-back data and aged count.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        hazard_d  = hazard_q;
        wdata_d   = wdata_q;
        advance_s = 1'b0;
        case (state_q)
            AGE_IDLE: begin
                if (start_s) begin
                    cnt_d    = 9'd0;
                    addr_d   = 8'd0;
                    hazard_d = 1'b0;
                    state_d  = AGE_RD;
                end else begin
                    state_d  = AGE_IDLE;
                end
            end
            AGE_RD: begin
                if (!age_en25) begin
                    state_d  = AGE_IDLE;
                end else begin
                    hazard_d = add_hit_s;
                    state_d  = AGE_CHK;
                end
            end
            AGE_CHK: begin
                if (!age_en25) begin
                    state_d = AGE_IDLE;
                end else if (expired_s && !(hazard_q || add_hit_s)) begin
                    wdata_d     = mem_read_data_age25;
                    wdata_d[VB] = 1'b0;
                    state_d     = AGE_WR;
                end else begin
                    advance_s = 1'b1;
                end
            end
            AGE_WR: begin
                if (!age_en25) begin
                    state_d = AGE_IDLE;
                end else begin
                    if (!add_hit_s) begin
                        cnt_d = cnt_q + 9'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    advance_s = 1'b1;
                end
            end
            AGE_DONE: state_d = AGE_IDLE;
            default:  state_d = AGE_IDLE;
        endcase
        if (advance_s) begin
            if (addr_q == LAST_ADDR) begin
                state_d = AGE_DONE;
            end else begin
                addr_d  = addr_q + 8'd1;
                state_d = AGE_RD;
            end
        end else begin
            addr_d = addr_d;
        end
    end

    // Sweep state registers.
    always_ff @(posedge pclk25) begin
        if (prst25) begin
            state_q  <= AGE_IDLE;
            addr_q   <= 8'd0;
            cnt_q    <= 9'd0;
            hazard_q <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            hazard_q <= hazard_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_addr_age25       = addr_q;
    assign mem_write_data_age25 = wdata_q;
    // A same-cycle add-port write to this entry, or an abort, suppresses the write-back.
    assign mem_write_age25      = (state_q == AGE_WR) && age_en25 && !add_hit_s;
    assign sweep_busy25         = (state_q == AGE_RD) || (state_q == AGE_CHK) || (state_q == AGE_WR);
    assign sweep_done25         = (state_q == AGE_DONE);
    assign aged_cnt25           = cnt_q;

endmodule

// File: tb/tb_alut_age_sched25.sv
// Self-checking bench for alut_age_sched25: table memory model plus a sweep schedule model.
module tb_alut_age_sched25;

`ifdef ALUT_AGE_AUTO_EN
    localparam int T_INTERVAL = 4;
`else
    localparam int T_INTERVAL = 1024;
`endif

    logic        clk = 1'b0;
    logic        prst25, age_en25, age_start25, tick25, mem_write_add25;
    logic [31:0] age_thresh25;
    logic [7:0]  mem_addr_add25;
    logic [82:0] rdata;
    logic [7:0]  mem_addr_age25;
    logic        mem_write_age25;
    logic [82:0] mem_write_data_age25;
    logic [31:0] cur_time25;
    logic        sweep_busy25, sweep_done25;
    logic [8:0]  aged_cnt25;

    alut_age_sched25 #(.AGE_INTERVAL(T_INTERVAL)) dut (
        .pclk25               (clk),
        .prst25               (prst25),
        .age_en25             (age_en25),
        .age_start25          (age_start25),
        .age_thresh25         (age_thresh25),
        .tick25               (tick25),
        .mem_addr_add25       (mem_addr_add25),
        .mem_write_add25      (mem_write_add25),
        .mem_read_data_age25  (rdata),
        .mem_addr_age25       (mem_addr_age25),
        .mem_write_age25      (mem_write_age25),
        .mem_write_data_age25 (mem_write_data_age25),
        .cur_time25           (cur_time25),
        .sweep_busy25         (sweep_busy25),
        .sweep_done25         (sweep_done25),
        .aged_cnt25           (aged_cnt25)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_time;
    logic [82:0] exp_mem [256];
    logic [82:0] mem [256];
    logic [82:0] add_data;
    logic        load_req;

    // Expected sweep schedule, indexed by cycle offset from the start cycle.
    int          exp_wr  [1024];
    logic [7:0]  exp_wa  [1024];
    logic [82:0] exp_wd  [1024];
    int          add_cyc [1024];
    int          exp_len, exp_cnt;
    int          cyc;
    bit          mon_on;
    int          done_cyc;
    int          wr_log [$];

    // Dual-port table memory: read-before-write, add port wins on a collision.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= exp_mem[i];
        end else begin
            if (mem_write_age25) mem[mem_addr_age25] <= mem_write_data_age25;
            if (mem_write_add25) mem[mem_addr_add25] <= add_data;
        end
        rdata <= mem[mem_addr_age25];
    end

    task automatic chk(input string nm, input logic [82:0] act, input logic [82:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [82:0] add_val(input int i);
        return {1'b1, 18'h2A5A5, 32'(i), ref_time};
    endfunction

    function automatic logic [82:0] mk_entry(input bit v, input int i, input logic [31:0] stamp);
        return {v, 18'h0, 32'(i) ^ 32'hC0DE_0000, stamp};
    endfunction

    task automatic load_mem();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); tick25 = 1'b1;
        end
        @(negedge clk); tick25 = 1'b0;
        ref_time += 32'(n);
    endtask

    task automatic do_reset();
        @(negedge clk); prst25 = 1'b1;
        @(negedge clk); @(negedge clk); prst25 = 1'b0;
        ref_time = 32'd0;
    endtask

    // Walk the table: each entry costs RD+CHK, plus WR if it is stale and not raced at CHK.
    task automatic plan_sweep(input int race_chk, input int race_wr);
        int          t;
        logic [31:0] age;
        bit          aged;
        for (int c = 0; c < 1024; c++) begin exp_wr[c] = 0; add_cyc[c] = -1; end
        exp_cnt = 0;
        t = 1;
        for (int i = 0; i < 256; i++) begin
            age  = ref_time - exp_mem[i][31:0];
            aged = exp_mem[i][82] && (age > age_thresh25) && (i != race_chk);
            if (i == race_chk) begin
                add_cyc[t+1] = i;
                exp_mem[i]   = add_val(i);
            end
            if (aged) begin
                if (i == race_wr) begin
                    add_cyc[t+2] = i;
                    exp_mem[i]   = add_val(i);
                end else begin
                    exp_wr[t+2] = 1;
                    exp_wa[t+2] = 8'(i);
                    exp_wd[t+2] = exp_mem[i] & ~(83'd1 << 82);
                    exp_mem[i]  = exp_wd[t+2];
                    exp_cnt++;
                end
                t += 3;
            end else begin
                t += 2;
            end
        end
        exp_len = t;
    endtask

    task automatic run_sweep();
        done_cyc = -1;
        wr_log.delete();
        @(negedge clk);
        cyc = 0; mon_on = 1'b1; age_start25 = 1'b1; mem_write_add25 = 1'b0;
        for (int c = 1; c <= exp_len + 2; c++) begin
            @(negedge clk);
            cyc = c; age_start25 = 1'b0;
            if (add_cyc[c] >= 0) begin
                mem_write_add25 = 1'b1;
                mem_addr_add25  = 8'(add_cyc[c]);
                add_data        = add_val(add_cyc[c]);
            end else begin
                mem_write_add25 = 1'b0;
            end
        end
        @(negedge clk); mon_on = 1'b0; mem_write_add25 = 1'b0;
    endtask

    task automatic check_after(input string tag);
        chk({tag, "_aged_cnt"}, aged_cnt25, exp_cnt);
        chk({tag, "_time"}, cur_time25, ref_time);
        for (int i = 0; i < 256; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
    endtask

    // Cycle-by-cycle comparison against the planned schedule while a sweep runs.
    always @(negedge clk) begin
        #2;
        if (mon_on) begin
            chk($sformatf("busy_c%0d", cyc), sweep_busy25, (cyc >= 1 && cyc < exp_len));
            chk($sformatf("done_c%0d", cyc), sweep_done25, (cyc == exp_len));
            chk($sformatf("wr_c%0d", cyc), mem_write_age25, (exp_wr[cyc] != 0));
            if (exp_wr[cyc] != 0) begin
                chk($sformatf("wa_c%0d", cyc), mem_addr_age25, exp_wa[cyc]);
                chk($sformatf("wd_c%0d", cyc), mem_write_data_age25, exp_wd[cyc]);
            end
            if (cyc == exp_len) chk("done_aged_cnt", aged_cnt25, exp_cnt);
            if (sweep_done25 && done_cyc < 0) done_cyc = cyc;
            if (mem_write_age25) wr_log.push_back(int'(mem_addr_age25));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        prst25 = 1'b1; age_en25 = 1'b0; age_start25 = 1'b0; age_thresh25 = 32'd0;
        tick25 = 1'b0; mem_addr_add25 = 8'd0; mem_write_add25 = 1'b0; add_data = '0;
        load_req = 1'b0; mon_on = 1'b0; cyc = 0; ref_time = 32'd0; done_cyc = -1;
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b0, i, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_addr", mem_addr_age25, 8'd0);
        chk("rst_wr", mem_write_age25, 1'b0);
        chk("rst_wdata", mem_write_data_age25, 83'd0);
        chk("rst_time", cur_time25, 32'd0);
        chk("rst_busy", sweep_busy25, 1'b0);
        chk("rst_done", sweep_done25, 1'b0);
        chk("rst_cnt", aged_cnt25, 9'd0);
        prst25 = 1'b0;
        load_mem();

`ifdef ALUT_AGE_AUTO_EN
        age_en25 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); tick25 = 1'b1;
            @(negedge clk); tick25 = 1'b0;
            #1 chk("auto_idle", sweep_busy25, 1'b0);
        end
        @(negedge clk); tick25 = 1'b1;
        #1 chk("auto_busy_tick4", sweep_busy25, 1'b0);
        @(negedge clk); tick25 = 1'b0;
        #1 chk("auto_busy_rise", sweep_busy25, 1'b1);
        seen = 0;
        for (int c = 0; c < 1000 && seen == 0; c++) begin
            @(negedge clk); #1;
            if (sweep_done25) seen = 1;
        end
        chk("auto_done_seen", seen, 1);
`else
        // No aging: every entry fresh.
        age_en25 = 1'b1;
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b1, i, 32'd0);
        load_mem();
        do_ticks(50);
        chk("time_50", cur_time25, 32'd50);
        age_thresh25 = 32'd100;
        plan_sweep(-1, -1);
        chk("model_len_noage", exp_len, 513);
        run_sweep();
        chk("noage_done_cycle", done_cyc, 513);
        chk("noage_writes", wr_log.size(), 0);
        chk("noage_cnt", aged_cnt25, 9'd0);
        check_after("noage");

        // Selective aging of entries 3 and 255.
        do_ticks(150);
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b0, i, 32'd0);
        exp_mem[3]   = mk_entry(1'b1, 3, 32'd0);
        exp_mem[255] = mk_entry(1'b1, 255, 32'd0);
        load_mem();
        plan_sweep(-1, -1);
        chk("model_len_sel", exp_len, 515);
        run_sweep();
        chk("sel_done_cycle", done_cyc, 515);
        chk("sel_write_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("sel_wr_addr0", wr_log[0], 3);
            chk("sel_wr_addr1", wr_log[1], 255);
        end
        chk("sel_vb3", mem[3][82], 1'b0);
        chk("sel_vb255", mem[255][82], 1'b0);
        chk("sel_cnt", aged_cnt25, 9'd2);
        check_after("sel");

        // Timestamp wrap: age 0x20 against thresholds 0x1F and 0x20.
        do_reset();
        do_ticks(16);
        chk("time_wrap", cur_time25, 32'h10);
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b0, i, 32'd0);
        exp_mem[9] = mk_entry(1'b1, 9, 32'hFFFF_FFF0);
        load_mem();
        age_thresh25 = 32'h1F;
        plan_sweep(-1, -1);
        run_sweep();
        chk("wrap_aged", aged_cnt25, 9'd1);
        check_after("wrap1f");
        exp_mem[9] = mk_entry(1'b1, 9, 32'hFFFF_FFF0);
        load_mem();
        age_thresh25 = 32'h20;
        plan_sweep(-1, -1);
        run_sweep();
        chk("wrap_not_aged", aged_cnt25, 9'd0);
        check_after("wrap20");

        // Add-port races: entry 5 at CHK, entry 7 at WR; entry 12 ages normally.
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b0, i, 32'd0);
        exp_mem[5]  = mk_entry(1'b1, 5, 32'd0);
        exp_mem[7]  = mk_entry(1'b1, 7, 32'd0);
        exp_mem[12] = mk_entry(1'b1, 12, 32'd0);
        load_mem();
        age_thresh25 = 32'd5;
        plan_sweep(5, 7);
        run_sweep();
        chk("race_cnt", aged_cnt25, 9'd1);
        chk("race_write_count", wr_log.size(), 1);
        if (wr_log.size() == 1) chk("race_wr_addr", wr_log[0], 12);
        chk("race_mem5", mem[5], add_val(5));
        chk("race_mem7", mem[7], add_val(7));
        check_after("race");

        // Randomized tables, thresholds and race positions.
        for (int r = 0; r < 3; r++) begin
            do_ticks($urandom_range(1, 40));
            for (int i = 0; i < 256; i++)
                exp_mem[i] = mk_entry(1'($urandom % 2), i, ref_time - 32'($urandom_range(0, 300)));
            load_mem();
            age_thresh25 = 32'($urandom_range(0, 300));
            plan_sweep(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            run_sweep();
            check_after($sformatf("rnd%0d", r));
        end

        // Abort at entry 40 after entries 10 and 20 have aged.
        for (int i = 0; i < 256; i++) exp_mem[i] = mk_entry(1'b0, i, 32'd0);
        exp_mem[10] = mk_entry(1'b1, 10, ref_time - 32'd100);
        exp_mem[20] = mk_entry(1'b1, 20, ref_time - 32'd100);
        exp_mem[40] = mk_entry(1'b1, 40, ref_time - 32'd100);
        load_mem();
        age_thresh25 = 32'd10;
        @(negedge clk); age_start25 = 1'b1;
        for (int c = 1; c <= 85; c++) begin
            @(negedge clk); age_start25 = 1'b0;
        end
        #1;
        chk("abort_addr", mem_addr_age25, 8'd40);
        chk("abort_busy_before", sweep_busy25, 1'b1);
        age_en25 = 1'b0;
        @(negedge clk); #1;
        chk("abort_idle", sweep_busy25, 1'b0);
        chk("abort_partial_cnt", aged_cnt25, 9'd2);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (sweep_done25 || mem_write_age25 || sweep_busy25) seen++;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_mem10", mem[10][82], 1'b0);
        chk("abort_mem20", mem[20][82], 1'b0);
        chk("abort_mem40", mem[40], exp_mem[40]);
        age_en25 = 1'b1;

        // Reset in the middle of a sweep.
        do_ticks(5);
        exp_mem[0] = mk_entry(1'b1, 0, ref_time - 32'd100);
        load_mem();
        @(negedge clk); age_start25 = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk); age_start25 = 1'b0;
        end
        #1 chk("mid_busy", sweep_busy25, 1'b1);
        prst25 = 1'b1;
        @(negedge clk); #1;
        chk("mrst_addr", mem_addr_age25, 8'd0);
        chk("mrst_wr", mem_write_age25, 1'b0);
        chk("mrst_wdata", mem_write_data_age25, 83'd0);
        chk("mrst_time", cur_time25, 32'd0);
        chk("mrst_busy", sweep_busy25, 1'b0);
        chk("mrst_done", sweep_done25, 1'b0);
        chk("mrst_cnt", aged_cnt25, 9'd0);
        prst25 = 1'b0;
        ref_time = 32'd0;
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
